// File: rtl/mano_io_port.sv
// mano_io_port: device-side I/O port of the basic computer.
//   Holds INPR/FGI (terminal -> CPU) and OUTR/FGO (CPU -> terminal), executes the
//   CPU I/O strobes INP, OUT, SKI, SKO, ION, IOF and raises the interrupt request R.
//   Optional feature macro: MANO_IO_INTR_EN (IEN register and registered R).
//   Without it, ION/IOF/INTACK are ignored and R is tied low (polled I/O only).
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   AC_LO[DW]                  AC low bits, loaded into OUTR on OUT
//   INP, OUT, SKI, SKO         CPU I/O strobes
//   ION, IOF, INTACK           interrupt enable / disable / interrupt cycle entered
//   INPR[DW], FGI, FGO         input register and flags
//   SKIP                       combinational skip condition
//   R                          interrupt request (registered)
//   DEV_IN_DATA/VALID/READY    terminal -> computer link (READY = ~FGI)
//   DEV_OUT_DATA/VALID/READY   computer -> terminal link (DATA = OUTR, VALID = ~FGO)
//
// state        | meaning
// IN_EMPTY     | FGI=0, INPR free, next offered character is accepted
// IN_FULL      | FGI=1, INPR holds a character until the CPU executes INP
// OUT_IDLE     | FGO=1, OUTR delivered, CPU may issue OUT
// OUT_PENDING  | FGO=0, OUTR offered to the terminal
module mano_io_port #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [DW-1:0] AC_LO,
  input  logic          INP,
  input  logic          OUT,
  input  logic          SKI,
  input  logic          SKO,
  input  logic          ION,
  input  logic          IOF,
  input  logic          INTACK,
  output logic [DW-1:0] INPR,
  output logic          FGI,
  output logic          FGO,
  output logic          SKIP,
  output logic          R,
  input  logic [DW-1:0] DEV_IN_DATA,
  input  logic          DEV_IN_VALID,
  output logic          DEV_IN_READY,
  output logic [DW-1:0] DEV_OUT_DATA,
  output logic          DEV_OUT_VALID,
  input  logic          DEV_OUT_READY
);

  typedef enum logic {IN_EMPTY = 1'b0, IN_FULL = 1'b1} in_state_t;
  typedef enum logic {OUT_PENDING = 1'b0, OUT_IDLE = 1'b1} out_state_t;

  in_state_t     in_state, in_next;
  out_state_t    out_state, out_next;
  logic [DW-1:0] inpr_q, inpr_next;
  logic [DW-1:0] outr_q, outr_next;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      in_state  <= IN_EMPTY;
      out_state <= OUT_IDLE;
      inpr_q    <= '0;
      outr_q    <= '0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      inpr_q    <= inpr_next;
      outr_q    <= outr_next;
    end
  end

  // Input path: INP while empty is harmless; an accept on that edge still sets FGI.
  always_comb begin
    in_next   = in_state;
    inpr_next = inpr_q;
    case (in_state)
      IN_EMPTY: begin
        if (DEV_IN_VALID) begin
          inpr_next = DEV_IN_DATA;
          in_next   = IN_FULL;
        end
      end
      IN_FULL: begin
        if (INP) in_next = IN_EMPTY;
      end
      default: in_next = IN_EMPTY;
    endcase
  end

  // Output path: OUT always wins, so a coincident READY delivers the old character
  // while the new one is latched and stays pending.
  always_comb begin
    out_next  = out_state;
    outr_next = outr_q;
    if (OUT) begin
      outr_next = AC_LO;
      out_next  = OUT_PENDING;
    end else if ((out_state == OUT_PENDING) && DEV_OUT_READY) begin
      out_next = OUT_IDLE;
    end
  end

  assign FGI           = (in_state == IN_FULL);
  assign FGO           = (out_state == OUT_IDLE);
  assign INPR          = inpr_q;
  assign SKIP          = (SKI & FGI) | (SKO & FGO);
  assign DEV_IN_READY  = ~FGI;
  assign DEV_OUT_DATA  = outr_q;
  assign DEV_OUT_VALID = ~FGO;

`ifdef MANO_IO_INTR_EN
  logic ien_q;
  logic r_q;

  // Clears act on the same edge for both IEN and R, so R drops one edge after
  // INTACK/IOF rather than lingering a cycle on the stale IEN.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ien_q <= 1'b0;
      r_q   <= 1'b0;
    end else begin
      if (INTACK || IOF) ien_q <= 1'b0;
      else if (ION)      ien_q <= 1'b1;
      r_q <= ien_q & (FGI | FGO) & ~INTACK & ~IOF;
    end
  end

  assign R = r_q;
`else
  logic unused_intr;
  assign unused_intr = ION ^ IOF ^ INTACK;
  assign R = 1'b0;
`endif

endmodule

// File: tb/tb_mano_io_port.sv
module tb_mano_io_port;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [DW-1:0] AC_LO;
  logic          INP, OUT, SKI, SKO, ION, IOF, INTACK;
  logic [DW-1:0] INPR;
  logic          FGI, FGO, SKIP, R;
  logic [DW-1:0] DEV_IN_DATA;
  logic          DEV_IN_VALID, DEV_IN_READY;
  logic [DW-1:0] DEV_OUT_DATA;
  logic          DEV_OUT_VALID, DEV_OUT_READY;

  int vectors = 0;
  int miscompares = 0;

  string       exp_tag[$];
  logic [31:0] exp_val[$];

  always #5 CLK = ~CLK;

  mano_io_port #(.DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .AC_LO(AC_LO),
    .INP(INP), .OUT(OUT), .SKI(SKI), .SKO(SKO),
    .ION(ION), .IOF(IOF), .INTACK(INTACK),
    .INPR(INPR), .FGI(FGI), .FGO(FGO), .SKIP(SKIP), .R(R),
    .DEV_IN_DATA(DEV_IN_DATA), .DEV_IN_VALID(DEV_IN_VALID), .DEV_IN_READY(DEV_IN_READY),
    .DEV_OUT_DATA(DEV_OUT_DATA), .DEV_OUT_VALID(DEV_OUT_VALID), .DEV_OUT_READY(DEV_OUT_READY)
  );

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_tag.push_back(tag);
    exp_val.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    vectors++;
    if (exp_val.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      t = exp_tag.pop_front();
      e = exp_val.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_v(tag, e);
    observe(obs);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b0; AC_LO = '0; INP = 0; OUT = 0; SKI = 0; SKO = 0;
    ION = 0; IOF = 0; INTACK = 0; DEV_IN_DATA = '0; DEV_IN_VALID = 0; DEV_OUT_READY = 0;
    tick(); tick();
    chk("rst_inpr", 32'(INPR), 32'h0);
    chk("rst_fgi", 32'(FGI), 32'h0);
    chk("rst_fgo", 32'(FGO), 32'h1);
    chk("rst_r", 32'(R), 32'h0);
    chk("rst_in_ready", 32'(DEV_IN_READY), 32'h1);
    chk("rst_out_valid", 32'(DEV_OUT_VALID), 32'h0);
    RST_N = 1'b1;
    tick();

    // input accept
    DEV_IN_DATA = 8'h41; DEV_IN_VALID = 1;
    expect_v("in_inpr_41", 32'h41);
    expect_v("in_fgi_set", 32'h1);
    expect_v("in_ready_low", 32'h0);
    tick();
    DEV_IN_VALID = 0;
    observe(32'(INPR)); observe(32'(FGI)); observe(32'(DEV_IN_READY));
    SKI = 1; #1;
    chk("ski_skip", 32'(SKIP), 32'h1);
    SKI = 0; #1;
    chk("no_strobe_skip", 32'(SKIP), 32'h0);

    // backpressure
    DEV_IN_DATA = 8'h42; DEV_IN_VALID = 1;
    expect_v("bp_inpr_held", 32'h41);
    tick();
    observe(32'(INPR));
    chk("bp_fgi_full", 32'(FGI), 32'h1);
    INP = 1;
    expect_v("inp_fgi_clr", 32'h0);
    expect_v("inp_inpr_held", 32'h41);
    tick();
    INP = 0;
    observe(32'(FGI)); observe(32'(INPR));
    expect_v("bp_inpr_42", 32'h42);
    tick();
    observe(32'(INPR));
    chk("bp_fgi_42", 32'(FGI), 32'h1);
    DEV_IN_VALID = 0;
    INP = 1; tick(); INP = 0;
    chk("inp2_fgi_clr", 32'(FGI), 32'h0);

    // INP while empty coinciding with accept: accept wins
    DEV_IN_DATA = 8'h43; DEV_IN_VALID = 1; INP = 1;
    tick();
    INP = 0; DEV_IN_VALID = 0;
    chk("inp_empty_fgi", 32'(FGI), 32'h1);
    chk("inp_empty_inpr", 32'(INPR), 32'h43);
    INP = 1; tick(); INP = 0;

    // output
    AC_LO = 8'h5A; OUT = 1;
    tick();
    OUT = 0;
    chk("out_data_5a", 32'(DEV_OUT_DATA), 32'h5A);
    chk("out_valid", 32'(DEV_OUT_VALID), 32'h1);
    chk("out_fgo_clr", 32'(FGO), 32'h0);
    SKO = 1; #1;
    chk("sko_pending_skip", 32'(SKIP), 32'h0);
    SKO = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("out_wait_fgo", 32'(FGO), 32'h0);
    DEV_OUT_READY = 1;
    tick();
    DEV_OUT_READY = 0;
    chk("out_done_fgo", 32'(FGO), 32'h1);
    SKO = 1; #1;
    chk("sko_skip", 32'(SKIP), 32'h1);
    SKO = 0;

    // overwrite then coincidence
    AC_LO = 8'h11; OUT = 1; tick();
    AC_LO = 8'h22; tick();
    OUT = 0;
    chk("ovw_data_22", 32'(DEV_OUT_DATA), 32'h22);
    chk("ovw_fgo", 32'(FGO), 32'h0);
    AC_LO = 8'h33; OUT = 1; DEV_OUT_READY = 1; #1;
    chk("coin_delivered_22", 32'({DEV_OUT_VALID, DEV_OUT_DATA}), 32'h122);
    tick();
    OUT = 0; DEV_OUT_READY = 0;
    chk("coin_data_33", 32'(DEV_OUT_DATA), 32'h33);
    chk("coin_fgo", 32'(FGO), 32'h0);
    DEV_OUT_READY = 1; tick(); DEV_OUT_READY = 0;
    chk("coin_done_fgo", 32'(FGO), 32'h1);

    // interrupt (FGO=1 here)
`ifdef MANO_IO_INTR_EN
    ION = 1; tick(); ION = 0;
    chk("ion_r_latency", 32'(R), 32'h0);
    tick();
    chk("ion_r_set", 32'(R), 32'h1);
    INTACK = 1; tick(); INTACK = 0;
    chk("intack_r_clr", 32'(R), 32'h0);
    tick();
    chk("intack_ien_clr", 32'(R), 32'h0);
    ION = 1; IOF = 1; tick(); tick(); ION = 0; IOF = 0; tick();
    chk("iof_wins", 32'(R), 32'h0);
    ION = 1; INTACK = 1; tick(); ION = 0; INTACK = 0; tick();
    chk("intack_wins", 32'(R), 32'h0);
    ION = 1; tick(); ION = 0; tick();
    chk("ion_again_r", 32'(R), 32'h1);
`else
    ION = 1; tick(); tick(); ION = 0; tick();
    chk("noint_r_ion", 32'(R), 32'h0);
    INTACK = 1; IOF = 1; tick(); INTACK = 0; IOF = 0;
    chk("noint_r_strobes", 32'(R), 32'h0);
`endif

    // reset mid-transfer
    DEV_IN_DATA = 8'h55; DEV_IN_VALID = 1; AC_LO = 8'h66; OUT = 1;
    tick();
    DEV_IN_VALID = 0; OUT = 0;
    chk("pre_rst_fgi", 32'(FGI), 32'h1);
    chk("pre_rst_fgo", 32'(FGO), 32'h0);
    #2 RST_N = 1'b0; #1;
    chk("arst_fgi", 32'(FGI), 32'h0);
    chk("arst_fgo", 32'(FGO), 32'h1);
    chk("arst_inpr", 32'(INPR), 32'h0);
    chk("arst_r", 32'(R), 32'h0);
    chk("arst_out_data", 32'(DEV_OUT_DATA), 32'h0);
    tick();
    RST_N = 1'b1;
    tick();

    if (exp_val.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_val.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
